// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the handshaked data memory.
//   - RV32 load/store funct3 codes
//   - FSM state encoding
//   - access_ok(): legality check (alignment, range, funct3)
//   - load_ext(): lane select plus sign/zero extension of a loaded word
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the access may touch memory. Any address bit at or above
  // addr_w puts the access outside the RAM.
  function automatic logic access_ok(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input int          addr_w);
    logic ok;
    ok = ((addr >> addr_w) == 32'd0);
    if (we) ok = ok && ((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
    else    ok = ok && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if ((f3[1:0] == 2'b01) && addr[0])          ok = 1'b0;
    if ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

  // Shift the addressed lane down to bit 0, then extend per funct3.
  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [31:0] word,
                                           input logic [1:0]  lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (f3)
      F3_B:    return {{24{sh[7]}}, sh[7:0]};
      F3_H:    return {{16{sh[15]}}, sh[15:0]};
      F3_W:    return sh;
      F3_BU:   return {24'd0, sh[7:0]};
      F3_HU:   return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// dmem_hs_if: request/response handshake bundle for dmem_hs.
//   request : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//   response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   master = requesting core, slave = memory.
interface dmem_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// dmem_bank: word-organised RAM with per-byte write enables.
//   clk   : write clock
//   addr  : word address (shared by read and write)
//   we    : write strobe, qualified per lane by be
//   be    : byte-lane enables, bit i covers wdata[8i+7:8i]
//   wdata : write data, already steered to its lanes
//   rdata : combinational read of mem[addr]
module dmem_bank #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing a RAM would need a write per word,
  // and callers must write before they read.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: byte-addressable little-endian RV32 data RAM behind valid/ready
// request and response channels, with LATENCY programmable wait cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_hs_if slave side (request and response channels)
//   busy     : an access is in flight (FSM not IDLE)
// Faulting accesses (misaligned, out of range, bad funct3) return
// rsp_err=1 and rsp_rdata=0 and never write memory.
module dmem_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst,
  dmem_hs_if.slave bus,
  output logic     busy
);

  localparam int         DEPTH    = 2 ** (ADDR_W - 2);
  localparam bit         ZERO_LAT = (LATENCY == 0);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic        lat_we;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        accept;
  logic        commit;
  logic        ok;
  logic        src_we;
  logic [2:0]  src_f3;
  logic [31:0] src_addr;
  logic [31:0] src_wdata;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic        bank_we;
  logic [31:0] rd_word;

  // The commit happens on the edge that enters RESP. With zero latency that
  // is the accepting edge, so the live request is used; otherwise the
  // latched copy taken at acceptance is used.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    accept    = bus.req_valid && bus.req_ready;
    src_we    = lat_we;
    src_f3    = lat_f3;
    src_addr  = lat_addr;
    src_wdata = lat_wdata;
    if (state == IDLE) begin
      src_we    = bus.req_we;
      src_f3    = bus.req_funct3;
      src_addr  = bus.req_addr;
      src_wdata = bus.req_wdata;
    end
    commit = ((state == IDLE) && accept && ZERO_LAT) ||
             ((state == WAIT) && (cnt == 3'd0));
    ok     = access_ok(src_we, src_f3, src_addr, ADDR_W);
    lane   = src_addr[1:0];
    case (src_f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    wr_data = src_wdata << {lane, 3'b000};
    bank_we = commit && src_we && ok;
  end

  dmem_bank #(.DEPTH(DEPTH)) u_bank (
    .clk  (clk),
    .addr (src_addr[ADDR_W-1:2]),
    .we   (bank_we),
    .be   (be),
    .wdata(wr_data),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      lat_we        <= 1'b0;
      lat_f3        <= 3'd0;
      lat_addr      <= 32'd0;
      lat_wdata     <= 32'd0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (commit) begin
        bus.rsp_err   <= !ok;
        bus.rsp_rdata <= (ok && !src_we) ? load_ext(src_f3, rd_word, lane) : 32'd0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we        <= bus.req_we;
            lat_f3        <= bus.req_funct3;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            if (ZERO_LAT) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised, handshaked successor to the single-cycle data memory.
- Byte-addressable little-endian RV32 data RAM behind a valid/ready request channel and a valid/ready response channel.
- Programmable wait states let multi-cycle and pipelined cores use it.
- Detects misaligned, out-of-range and illegal-funct3 accesses and reports them on rsp_err instead of silently accepting them.

Parameters:
- ADDR_W, 10: byte-address width actually decoded; capacity is 2^ADDR_W bytes (legal range 3..16).
- LATENCY, 1: wait cycles between request acceptance and response (0..7).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 width/sign code (instruction[14:12])
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used for SB/SH
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
- rsp_err  out  1  access faulted; no memory side effect
- busy  out  1  request in flight (state != IDLE)

Behaviour:
- Reset (async, rst=1): state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. RAM contents are not cleared; they are undefined until written.
- Storage: 2^(ADDR_W-2) words of 32 bits with 4 byte-lane enables. Lane = addr[1:0]. Little-endian.
- FSM IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we/funct3/addr/wdata.
  - If LATENCY=0, go to RESP; otherwise go to WAIT with counter=LATENCY-1.
- FSM WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At counter==0, go to RESP.
- Commit on the cycle the FSM enters RESP:
  - Store: byte enables written if no error.
  - Load: rsp_rdata registered.
  - rsp_err registered.
  - Request-to-rsp_valid latency is LATENCY+1 cycles.
- FSM RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err held stable until rsp_ready=1.
  - Then go to IDLE and clear rsp_valid. There is no same-cycle re-accept, so back-to-back throughput is one access per LATENCY+2 cycles.
- Load extension:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store widths: 000 SB, 001 SH, 010 SW.
- Error conditions (any one sets rsp_err=1, rsp_rdata=0, no write):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - req_addr >= 2^ADDR_W, i.e. any set bit above ADDR_W-1.
  - Load funct3 011, 110 or 111.
  - Store funct3 other than 000/001/010.
- Read during own write is impossible: one access in flight.
- Reset mid-operation returns to IDLE. A store not yet committed (still in WAIT) is discarded. An already-committed store is retained.
- req_* inputs are ignored whenever req_ready=0.

Decomposition:
- Package dmem_pkg:
  - funct3 localparams F3_B/H/W/BU/HU.
  - FSM state enum IDLE/WAIT/RESP.
  - Function that checks access legality.
  - Function that builds the extended load result.
- Sub-module dmem_bank:
  - Word RAM with 4-bit byte-write enable, synchronous write, combinational read.
  - Parametrised by word depth.
- dmem_hs owns the FSM, wait counter, lane steering and error logic.

Test Plan:
- SW 0x8000_00FF @0x10, then LW @0x10 (LATENCY=1) -> rsp_valid 2 cycles after accept, rdata=0x8000_00FF, err=0.
- SB 0xA5 @0x13, then LB @0x13 -> 0xFFFF_FFA5; LBU @0x13 -> 0x0000_00A5; LW @0x10 -> 0xA500_00FF.
- SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF_8001; LHU -> 0x0000_8001.
- LW @0x11, SH @0x23, LW @0x400 (ADDR_W=10), load funct3=011 -> each err=1, rdata=0; a following LW shows memory unchanged.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0. LATENCY=0 build -> rsp_valid 1 cycle after accept.
- Assert rst while a SW is in WAIT (LATENCY=4) -> all outputs return to reset values immediately; later LW of that address returns the pre-store value.
